byte2_pkt_finder: RTL and testbench

Stream-side packet extractor that scans each 256-bit data beat for two-byte packets. A packet is a sync word followed by one 16-bit payload word. Every clock the block reports the first payload found in the beat, how many payloads were found, and whether any were found. It sits behind the wide ingress datapath and feeds two-byte control packets to downstream logic.

---
 rtl/byte2_pkt_pkg.sv | 14 +
 rtl/byte2_word_scan.sv | 54 +++++
 rtl/byte2_pkt_finder.sv | 60 ++++++
 tb/tb_byte2_pkt_finder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/byte2_pkt_pkg.sv
// byte2_pkt_pkg
//   Shared constants for the two-byte packet finder: word width, number of
//   words per 256-bit beat, the default sync marker and the width of the
//   per-beat payload count.
package byte2_pkt_pkg;

  localparam int                      PKT_DATA_W    = 256;
  localparam int                      PKT_WORD_W    = 16;
  localparam int                      PKT_WORDS     = PKT_DATA_W / PKT_WORD_W;
  localparam logic [PKT_WORD_W-1:0]   PKT_SYNC_WORD = 16'h00FF;
  // At most 8 payloads fit in one beat (counting a carried-in payload), so 4 bits.
  localparam int                      PKT_CNT_W     = 4;

endpackage

// File: rtl/byte2_word_scan.sv
// byte2_word_scan
//   Purely combinational scan of one beat for sync/payload pairs, walking the
//   words in stream order (highest word first).
// Ports:
//   beat       beat to scan; word NWORDS-1 is first in stream order
//   carry_in   previous beat ended on an unconsumed sync, so the first word
//              of this beat is a payload
//   first_pkt  earliest payload in stream order (0 when none)
//   found      at least one payload in the beat
//   count      number of payloads in the beat
//   carry_out  last word of the beat is an unconsumed sync
module byte2_word_scan
  import byte2_pkt_pkg::*;
#(
  parameter int                  DATA_W    = PKT_DATA_W,
  parameter int                  WORD_W    = PKT_WORD_W,
  parameter logic [WORD_W-1:0]   SYNC_WORD = PKT_SYNC_WORD
) (
  input  logic [DATA_W-1:0]    beat,
  input  logic                 carry_in,
  output logic [WORD_W-1:0]    first_pkt,
  output logic                 found,
  output logic [PKT_CNT_W-1:0] count,
  output logic                 carry_out
);

  localparam int NWORDS = DATA_W / WORD_W;

  logic              skip;
  logic [WORD_W-1:0] w;

  // skip marks that the current word belongs to the preceding sync, so it is
  // consumed as a payload and can never itself start a new packet.
  always_comb begin
    skip      = carry_in;
    found     = 1'b0;
    count     = '0;
    first_pkt = '0;
    w         = '0;
    for (int i = NWORDS - 1; i >= 0; i--) begin
      w = beat[i*WORD_W +: WORD_W];
      if (skip) begin
        if (!found) first_pkt = w;
        found = 1'b1;
        count = count + PKT_CNT_W'(1);
        skip  = 1'b0;
      end else if (w == SYNC_WORD) begin
        skip = 1'b1;
      end
    end
    carry_out = skip;
  end

endmodule

// File: rtl/byte2_pkt_finder.sv
// byte2_pkt_finder
//   Extracts two-byte packets (sync word + one payload word) from a 256-bit
//   beat every cycle, with a sync in the last word carried into the next beat.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_in      beat sampled every cycle; data_in[255:240] is first in stream
//   byte2_pkt    first payload of the last sampled beat; holds when none
//   byte2_valid  last sampled beat had at least one payload
//   pkt_cnt      number of payloads in the last sampled beat (0..8)
module byte2_pkt_finder
  import byte2_pkt_pkg::*;
#(
  parameter int                  DATA_W    = PKT_DATA_W,
  parameter int                  WORD_W    = PKT_WORD_W,
  parameter logic [WORD_W-1:0]   SYNC_WORD = PKT_SYNC_WORD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    data_in,
  output logic [WORD_W-1:0]    byte2_pkt,
  output logic                 byte2_valid,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  logic                 carry_r;
  logic [WORD_W-1:0]    scan_pkt;
  logic                 scan_found;
  logic [PKT_CNT_W-1:0] scan_cnt;
  logic                 scan_carry;

  byte2_word_scan #(
    .DATA_W    (DATA_W),
    .WORD_W    (WORD_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_scan (
    .beat      (data_in),
    .carry_in  (carry_r),
    .first_pkt (scan_pkt),
    .found     (scan_found),
    .count     (scan_cnt),
    .carry_out (scan_carry)
  );

  // Output stage: register scan results; the carry is reloaded every beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte2_pkt   <= '0;
      byte2_valid <= 1'b0;
      pkt_cnt     <= '0;
      carry_r     <= 1'b0;
    end else begin
      if (scan_found) byte2_pkt <= scan_pkt;
      byte2_valid <= scan_found;
      pkt_cnt     <= scan_cnt;
      carry_r     <= scan_carry;
    end
  end

endmodule

// File: tb/tb_byte2_pkt_finder.sv
module tb_byte2_pkt_finder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] data_in = '0;
  logic [15:0]  byte2_pkt;
  logic         byte2_valid;
  logic [3:0]   pkt_cnt;

  always #5 clk = ~clk;

  byte2_pkt_finder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .byte2_pkt   (byte2_pkt),
    .byte2_valid (byte2_valid),
    .pkt_cnt     (pkt_cnt)
  );

  typedef struct packed {
    logic [15:0] pkt;
    logic [3:0]  cnt;
    logic        vld;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic        m_carry = 1'b0;
  logic [15:0] m_pkt = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: index walk over the beat in stream order.
  task automatic model_push(input logic [255:0] beat);
    logic [15:0] w[16];
    int          k;
    int          cnt;
    logic [15:0] first;
    logic        have;
    exp_t        e;
    for (int i = 0; i < 16; i++) w[i] = beat[255-16*i -: 16];
    k = 0; cnt = 0; have = 1'b0; first = m_pkt;
    if (m_carry) begin
      first = w[0]; have = 1'b1; cnt = 1; k = 1;
    end
    m_carry = 1'b0;
    while (k < 16) begin
      if (w[k] == 16'h00ff) begin
        if (k == 15) begin
          m_carry = 1'b1;
          k++;
        end else begin
          if (!have) begin first = w[k+1]; have = 1'b1; end
          cnt++;
          k += 2;
        end
      end else begin
        k++;
      end
    end
    m_pkt = first;
    e.pkt = first;
    e.cnt = cnt[3:0];
    e.vld = (cnt != 0);
    sb_q.push_back(e);
  endtask

  task automatic step(input string tag, input logic [255:0] beat);
    exp_t e;
    data_in = beat;
    model_push(beat);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, "_pkt"}, 32'(byte2_pkt),   32'(e.pkt));
    chk({tag, "_cnt"}, 32'(pkt_cnt),     32'(e.cnt));
    chk({tag, "_vld"}, 32'(byte2_valid), 32'(e.vld));
  endtask

  logic [255:0] beat;

  initial begin
    // Reset held with zero data
    rst_n   = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt", 32'(byte2_pkt),   32'h0);
    chk("rst_vld", 32'(byte2_valid), 32'h0);
    chk("rst_cnt", 32'(pkt_cnt),     32'h0);
    rst_n = 1'b1;
    step("rel", '0);
    chk("rel_cnt_c", 32'(pkt_cnt), 32'h0);

    step("tp1", 256'h00ff_0000_00ff_0003_08ff_1111_1234_ce10_1234_000f_08ff_1111_1234_ce10_1234_000f);
    chk("tp1_pkt_c", 32'(byte2_pkt), 32'h0000);
    chk("tp1_cnt_c", 32'(pkt_cnt),   32'h2);

    for (int i = 0; i < 3; i++)
      step("tp2", 256'h00ff_0002_00ff_0003_08ff_1111_1234_ce10_1234_000f_08ff_1111_123f_ce10_1230_000f);
    chk("tp2_pkt_c", 32'(byte2_pkt), 32'h0002);
    chk("tp2_cnt_c", 32'(pkt_cnt),   32'h2);

    // Cross-beat carry
    step("cy0", 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_0001_00ff);
    step("cy1", 256'habcd_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000);
    chk("cy1_pkt_c", 32'(byte2_pkt), 32'habcd);
    chk("cy1_cnt_c", 32'(pkt_cnt),   32'h1);

    // Payload equal to sync is not a sync
    step("ss0", 256'h00ff_00ff_00ff_0005_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000);
    chk("ss0_pkt_c", 32'(byte2_pkt), 32'h00ff);
    chk("ss0_cnt_c", 32'(pkt_cnt),   32'h2);
    step("ss1", '0);
    chk("ss1_pkt_c", 32'(byte2_pkt),   32'h00ff);
    chk("ss1_vld_c", 32'(byte2_valid), 32'h0);

    // Density extremes: 7 payloads + carry, then all-sync beat with carry in
    step("dn0", {16'h1234, {15{16'h00ff}}});
    chk("dn0_cnt_c", 32'(pkt_cnt), 32'h7);
    step("dn1", {16{16'h00ff}});
    chk("dn1_cnt_c", 32'(pkt_cnt), 32'h8);
    step("dn2", {16{16'h00ff}});

    // Reset mid-stream drops a pending carry
    step("mr0", 256'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_00ff);
    rst_n = 1'b0;
    #1;
    chk("mr_async_cnt", 32'(pkt_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_carry = 1'b0;
    m_pkt   = '0;
    step("mr1", 256'habcd_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000);
    chk("mr1_cnt_c", 32'(pkt_cnt), 32'h0);

    // Random beats with dense sync words
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < 16; j++)
        beat[16*j +: 16] = ($urandom_range(0, 1) == 1) ? 16'h00ff : 16'($urandom);
      step("rnd", beat);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
